// File: rtl/game_sequencer_pkg.sv
// Shared encodings for the game sequencer: FSM state codes and copy-source
// selects driven onto the datapath memory mux.
package game_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_LOAD_TITLE      = 4'd0,
      ST_TITLE           = 4'd1,
      ST_LOAD_STAGE      = 4'd2,
      ST_DRAW_TILE       = 4'd3,
      ST_UPDATE_TILE     = 4'd4,
      ST_DRAW_PLAYER     = 4'd5,
      ST_GAME_IDLE       = 4'd6,
      ST_PAUSED          = 4'd7,
      ST_UPDATE_STAGE    = 4'd8,
      ST_LOAD_WIN_SCREEN = 4'd9,
      ST_WIN_SCREEN      = 4'd10
   } state_t;

   localparam logic [1:0] MEM_TITLE = 2'd0;
   localparam logic [1:0] MEM_STAGE = 2'd1;
   localparam logic [1:0] MEM_WIN   = 2'd2;
   localparam logic [1:0] MEM_BUF   = 2'd3;

   // The game timebase runs through the whole redraw/update loop, but not while paused.
   function automatic logic timebase_active(input state_t s);
      return s inside {ST_DRAW_TILE, ST_UPDATE_TILE, ST_DRAW_PLAYER,
                       ST_GAME_IDLE, ST_UPDATE_STAGE};
   endfunction

endpackage

// File: rtl/game_sequencer_tick_timer.sv
// Game-logic timebase: frame prescaler and frame counter as down-counters,
// plus the pending-tick flag and sticky overrun detection.
module game_sequencer_tick_timer #(
   parameter int CLOCKS_PER_FRAME = 833333,
   parameter int FRAMES_PER_TICK  = 15
) (
   input  logic clock,
   input  logic resetn,
   input  logic run,
   input  logic clear,
   input  logic ack,
   output logic tick_pending,
   output logic overrun
);

   localparam int PS_W = (CLOCKS_PER_FRAME > 1) ? $clog2(CLOCKS_PER_FRAME) : 1;
   localparam int FC_W = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
   localparam logic [PS_W-1:0] PS_LOAD = PS_W'(CLOCKS_PER_FRAME - 1);
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FRAMES_PER_TICK - 1);

   logic [PS_W-1:0] ps_q;
   logic [FC_W-1:0] fc_q;
   logic            pending_q;
   logic            overrun_q;
   logic            frame_tc;
   logic            tick;

   assign frame_tc = run & (ps_q == '0);
   assign tick     = frame_tc & (fc_q == '0);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ps_q      <= '0;
         fc_q      <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else if (clear) begin
         ps_q      <= PS_LOAD;
         fc_q      <= FC_LOAD;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (run) begin
            ps_q <= frame_tc ? PS_LOAD : ps_q - PS_W'(1);
            if (frame_tc)
               fc_q <= (fc_q == '0) ? FC_LOAD : fc_q - FC_W'(1);
         end
         // A tick coinciding with the acknowledge wins, so that tick is kept.
         if (tick)
            pending_q <= 1'b1;
         else if (ack)
            pending_q <= 1'b0;
         if (tick && pending_q && !ack)
            overrun_q <= 1'b1;
      end
   end

   assign tick_pending = pending_q;
   assign overrun      = overrun_q;

endmodule

// File: rtl/game_sequencer.sv
// Top-level game control FSM: title, stage load, per-tick redraw loop of tiles
// and NUM_PLAYERS sprites, win screen, then back to title.
//
// state              | meaning
// LOAD_TITLE         | copy title ROM to the frame buffer
// TITLE              | wait for a go press
// LOAD_STAGE         | copy stage ROM, reset players/stage, clear timebase
// DRAW_TILE          | copy one tile into the frame buffer
// UPDATE_TILE        | advance tile counter, pick next tile or start sprites
// DRAW_PLAYER        | draw sprite player_sel
// GAME_IDLE          | wait for a pending tick
// PAUSED             | timebase frozen until pause drops
// UPDATE_STAGE       | one game-logic step, acknowledge the tick
// LOAD_WIN_SCREEN    | copy win ROM
// WIN_SCREEN         | wait for a go press
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int CLOCKS_PER_FRAME = 833333,
   parameter int FRAMES_PER_TICK  = 15,
   parameter int NUM_PLAYERS      = 2,
   localparam int PW              = $clog2(NUM_PLAYERS)
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   go,
   input  logic                   pause,
   input  logic                   finished,
   input  logic                   all_tiles_drawn,
   input  logic                   game_over,
   input  logic [PW-1:0]          winner,
   output logic [1:0]             memory_select,
   output logic                   copy_enable,
   output logic                   tc_enable,
   output logic                   player_reset,
   output logic                   stage_reset,
   output logic                   draw_t,
   output logic [NUM_PLAYERS-1:0] draw_player,
   output logic [PW-1:0]          player_sel,
   output logic                   update_stage,
   output logic [PW-1:0]          win_id,
   output logic                   tick_overrun
);

   localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

   state_t        state_q, state_d;
   logic [PW-1:0] player_sel_q, player_sel_d;
   logic [PW-1:0] win_id_q;
   logic          go_prev_q;
   logic          go_rise;
   logic          tick_pending;
   logic          tb_run, tb_clear, tb_ack;

   assign go_rise = go & ~go_prev_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_LOAD_TITLE;
         player_sel_q <= '0;
         win_id_q     <= '0;
         go_prev_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         player_sel_q <= player_sel_d;
         go_prev_q    <= go;
         if (state_q == ST_UPDATE_STAGE && game_over)
            win_id_q <= winner;
      end
   end

   always_comb begin
      state_d       = state_q;
      player_sel_d  = player_sel_q;
      memory_select = MEM_TITLE;
      copy_enable   = 1'b0;
      tc_enable     = 1'b0;
      player_reset  = 1'b0;
      stage_reset   = 1'b0;
      draw_t        = 1'b0;
      draw_player   = '0;
      update_stage  = 1'b0;
      case (state_q)
         ST_LOAD_TITLE: begin
            memory_select = MEM_TITLE;
            copy_enable   = 1'b1;
            if (finished) state_d = ST_TITLE;
         end
         ST_TITLE: begin
            if (go_rise) state_d = ST_LOAD_STAGE;
         end
         ST_LOAD_STAGE: begin
            memory_select = MEM_STAGE;
            copy_enable   = 1'b1;
            player_reset  = 1'b1;
            stage_reset   = 1'b1;
            if (finished) state_d = ST_DRAW_TILE;
         end
         ST_DRAW_TILE: begin
            memory_select = MEM_BUF;
            copy_enable   = 1'b1;
            draw_t        = 1'b1;
            if (finished) state_d = ST_UPDATE_TILE;
         end
         ST_UPDATE_TILE: begin
            tc_enable = 1'b1;
            if (all_tiles_drawn) begin
               state_d      = ST_DRAW_PLAYER;
               player_sel_d = '0;
            end else begin
               state_d = ST_DRAW_TILE;
            end
         end
         ST_DRAW_PLAYER: begin
            memory_select = MEM_BUF;
            copy_enable   = 1'b1;
            for (int i = 0; i < NUM_PLAYERS; i++)
               draw_player[i] = (player_sel_q == PW'(i));
            if (finished) begin
               if (player_sel_q == LAST_PLAYER)
                  state_d = ST_GAME_IDLE;
               else
                  player_sel_d = player_sel_q + PW'(1);
            end
         end
         ST_GAME_IDLE: begin
            if (pause)
               state_d = ST_PAUSED;
            else if (tick_pending)
               state_d = ST_UPDATE_STAGE;
         end
         ST_PAUSED: begin
            if (!pause) state_d = ST_GAME_IDLE;
         end
         ST_UPDATE_STAGE: begin
            update_stage = 1'b1;
            state_d      = game_over ? ST_LOAD_WIN_SCREEN : ST_DRAW_TILE;
         end
         ST_LOAD_WIN_SCREEN: begin
            memory_select = MEM_WIN;
            copy_enable   = 1'b1;
            if (finished) state_d = ST_WIN_SCREEN;
         end
         ST_WIN_SCREEN: begin
            if (go_rise) state_d = ST_LOAD_TITLE;
         end
         default: state_d = ST_LOAD_TITLE;
      endcase
   end

   assign tb_run   = timebase_active(state_q);
   assign tb_clear = (state_q == ST_LOAD_STAGE);
   assign tb_ack   = (state_q == ST_UPDATE_STAGE);

   game_sequencer_tick_timer #(
      .CLOCKS_PER_FRAME (CLOCKS_PER_FRAME),
      .FRAMES_PER_TICK  (FRAMES_PER_TICK)
   ) u_tick_timer (
      .clock        (clock),
      .resetn       (resetn),
      .run          (tb_run),
      .clear        (tb_clear),
      .ack          (tb_ack),
      .tick_pending (tick_pending),
      .overrun      (tick_overrun)
   );

   assign player_sel = player_sel_q;
   assign win_id     = win_id_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a 4-clock frame, 3-frame tick and
// three players; expected outputs and strobe timing are hand-derived.
module tb_game_sequencer;

   localparam int NP = 3;
   localparam int PW = 2;

   logic          clock = 1'b0;
   logic          resetn, go, pause, finished, all_tiles_drawn, game_over;
   logic [PW-1:0] winner;
   logic [1:0]    memory_select;
   logic          copy_enable, tc_enable, player_reset, stage_reset, draw_t;
   logic [NP-1:0] draw_player;
   logic [PW-1:0] player_sel, win_id;
   logic          update_stage, tick_overrun;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int cyc0 = 0;
   int n;
   int tc_count;
   logic seen_us;
   logic [10:0] ov;

   game_sequencer #(
      .CLOCKS_PER_FRAME (4),
      .FRAMES_PER_TICK  (3),
      .NUM_PLAYERS      (NP)
   ) dut (
      .clock           (clock),
      .resetn          (resetn),
      .go              (go),
      .pause           (pause),
      .finished        (finished),
      .all_tiles_drawn (all_tiles_drawn),
      .game_over       (game_over),
      .winner          (winner),
      .memory_select   (memory_select),
      .copy_enable     (copy_enable),
      .tc_enable       (tc_enable),
      .player_reset    (player_reset),
      .stage_reset     (stage_reset),
      .draw_t          (draw_t),
      .draw_player     (draw_player),
      .player_sel      (player_sel),
      .update_stage    (update_stage),
      .win_id          (win_id),
      .tick_overrun    (tick_overrun)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   assign ov = {memory_select, copy_enable, tc_enable, player_reset, stage_reset,
                draw_t, draw_player, update_stage};

   function automatic logic [10:0] o(input logic [1:0] sel, input logic cp, input logic tc,
                                     input logic pr, input logic sr, input logic dt,
                                     input logic [2:0] dp, input logic us);
      return {sel, cp, tc, pr, sr, dt, dp, us};
   endfunction

   localparam logic [10:0] O_ZERO   = 11'b00_0_0_0_0_0_000_0;
   localparam logic [10:0] O_LTITLE = 11'b00_1_0_0_0_0_000_0;
   localparam logic [10:0] O_LSTAGE = 11'b01_1_0_1_1_0_000_0;
   localparam logic [10:0] O_DTILE  = 11'b11_1_0_0_0_1_000_0;
   localparam logic [10:0] O_UTILE  = 11'b00_0_1_0_0_0_000_0;
   localparam logic [10:0] O_USTAGE = 11'b00_0_0_0_0_0_000_1;
   localparam logic [10:0] O_LWIN   = 11'b10_1_0_0_0_0_000_0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_fin();
      finished = 1'b1;
      step();
      finished = 1'b0;
   endtask

   task automatic wait_strobe(input int max, output int steps);
      steps = 0;
      while (update_stage !== 1'b1 && steps < max) begin
         step();
         steps++;
      end
   endtask

   // From DRAW_TILE: one tile, then all three sprites, ending in GAME_IDLE.
   task automatic short_redraw(input string tag);
      chk({tag, "_dtile"}, 32'(ov), 32'(O_DTILE));
      pulse_fin();
      chk({tag, "_utile"}, 32'(ov), 32'(O_UTILE));
      all_tiles_drawn = 1'b1;
      step();
      all_tiles_drawn = 1'b0;
      for (int p = 0; p < NP; p++) pulse_fin();
      chk({tag, "_idle"}, 32'(ov), 32'(O_ZERO));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; go = 1'b0; pause = 1'b0; finished = 1'b0;
      all_tiles_drawn = 1'b0; game_over = 1'b0; winner = '0;
      step(); step();
      chk("rst_outs", 32'(ov), 32'(O_LTITLE));
      chk("rst_win_id", 32'(win_id), 0);
      chk("rst_overrun", 32'(tick_overrun), 0);
      chk("rst_player_sel", 32'(player_sel), 0);
      resetn = 1'b1;
      step();
      chk("load_title_hold", 32'(ov), 32'(O_LTITLE));
      pulse_fin();
      chk("title", 32'(ov), 32'(O_ZERO));
      pulse_fin();
      chk("title_ignores_finished", 32'(ov), 32'(O_ZERO));
      go = 1'b1;
      step();
      chk("load_stage", 32'(ov), 32'(O_LSTAGE));
      for (int i = 0; i < 9; i++) step();
      chk("load_stage_go_held", 32'(ov), 32'(O_LSTAGE));
      go = 1'b0;

      // First redraw: five tiles, three sprites
      finished = 1'b1;
      step();
      finished = 1'b0;
      cyc0 = cyc;
      chk("loop1_dtile", 32'(ov), 32'(O_DTILE));
      tc_count = 0;
      for (int i = 0; i < 5; i++) begin
         if (tc_enable === 1'b1) tc_count++;
         pulse_fin();
         if (tc_enable === 1'b1) tc_count++;
         all_tiles_drawn = (i == 4);
         step();
         all_tiles_drawn = 1'b0;
      end
      chk("tc_pulses", 32'(tc_count), 5);
      for (int p = 0; p < NP; p++) begin
         chk("draw_player", 32'(ov), 32'(o(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001 << p, 1'b0)));
         chk("player_sel", 32'(player_sel), 32'(p));
         pulse_fin();
      end
      chk("loop1_idle", 32'(ov), 32'(O_ZERO));
      chk("loop1_idle_rel", 32'(cyc - cyc0), 13);
      wait_strobe(40, n);
      chk("strobe1_rel", 32'(cyc - cyc0), 14);
      chk("strobe1_overrun", 32'(tick_overrun), 0);

      step();
      short_redraw("loop2");
      wait_strobe(40, n);
      chk("strobe2_rel", 32'(cyc - cyc0), 25);

      step();
      short_redraw("loop3");
      wait_strobe(40, n);
      chk("strobe3_rel", 32'(cyc - cyc0), 37);

      // Pause from GAME_IDLE with four active cycles left before the next tick
      step();
      short_redraw("loop4");
      pause = 1'b1;
      seen_us = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (update_stage !== 1'b0) seen_us = 1'b1;
      end
      chk("pause_no_strobe", 32'(seen_us), 0);
      chk("paused_outs", 32'(ov), 32'(O_ZERO));
      pause = 1'b0;
      wait_strobe(40, n);
      chk("resume_strobe_delay", 32'(n), 6);
      chk("resume_strobe", 32'(ov), 32'(O_USTAGE));

      // Stall a tile copy long enough for two ticks
      step();
      chk("stall_dtile", 32'(ov), 32'(O_DTILE));
      chk("stall_overrun_start", 32'(tick_overrun), 0);
      for (int i = 0; i < 15; i++) step();
      chk("stall_overrun_mid", 32'(tick_overrun), 0);
      for (int i = 0; i < 15; i++) step();
      chk("stall_overrun_set", 32'(tick_overrun), 1);
      game_over = 1'b1;
      winner = 2'd2;
      short_redraw("loop5");
      wait_strobe(40, n);
      chk("final_strobe", 32'(ov), 32'(O_USTAGE));
      chk("overrun_sticky_us", 32'(tick_overrun), 1);
      step();
      chk("load_win", 32'(ov), 32'(O_LWIN));
      chk("win_id", 32'(win_id), 2);
      go = 1'b1;
      step();
      pulse_fin();
      chk("win_screen", 32'(ov), 32'(O_ZERO));
      pulse_fin();
      chk("win_ignores_finished", 32'(ov), 32'(O_ZERO));
      step(); step();
      chk("win_go_held", 32'(ov), 32'(O_ZERO));
      go = 1'b0;
      step();
      go = 1'b1;
      step();
      chk("back_to_title", 32'(ov), 32'(O_LTITLE));
      chk("overrun_sticky_title", 32'(tick_overrun), 1);
      chk("win_id_kept", 32'(win_id), 2);
      game_over = 1'b0;
      winner = '0;
      pulse_fin();
      step(); step(); step();
      chk("title_go_held", 32'(ov), 32'(O_ZERO));
      go = 1'b0;
      step();
      go = 1'b1;
      step();
      chk("load_stage2", 32'(ov), 32'(O_LSTAGE));
      step();
      chk("overrun_cleared", 32'(tick_overrun), 0);
      go = 1'b0;

      // Asynchronous reset in the middle of sprite drawing
      pulse_fin();
      pulse_fin();
      all_tiles_drawn = 1'b1;
      step();
      all_tiles_drawn = 1'b0;
      pulse_fin();
      chk("pre_reset_dp", 32'(ov), 32'(o(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0)));
      resetn = 1'b0;
      #2;
      chk("async_rst_outs", 32'(ov), 32'(O_LTITLE));
      chk("async_rst_sel", 32'(player_sel), 0);
      chk("async_rst_win_id", 32'(win_id), 0);
      step();
      resetn = 1'b1;
      step();
      chk("post_reset_outs", 32'(ov), 32'(O_LTITLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
